// File: rtl/axis_stream_buffer.sv
// axis_stream_buffer: collects words from a local write port and drains them
// as one AXI4-Stream burst. The drain order is FIFO or LIFO, set by a parameter.
// The burst length is captured when the drain starts. In FIFO mode, words
// written during a drain stay stored for the next burst.
module axis_stream_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LIFO   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     wr_en,
  input  logic                     op_en,
  output logic [DATA_W-1:0]        m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     wr_drop,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam bit IS_LIFO = (LIFO != 0);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE     = (AW+1)'(1);
  localparam logic [AW:0]   TWO     = (AW+1)'(2);
  localparam logic [AW-1:0] A_ONE   = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } state_t;

  state_t              state_q, state_d;
  logic [AW:0]         count_q, count_d;
  logic [AW:0]         burst_rem_q, burst_rem_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic                drop_q, drop_d;
  logic                done_q, done_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                push;
  logic                pop;
  logic                handshake;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       rd_idx;
  logic [DATA_W-1:0]   pop_data;

  // In stack mode the top of the stack is the slot just below count.
  // In queue mode the circular pointers are used.
  assign wr_idx    = IS_LIFO ? count_q[AW-1:0] : wr_ptr_q;
  assign rd_idx    = IS_LIFO ? (count_q[AW-1:0] - A_ONE) : rd_ptr_q;
  assign pop_data  = mem[rd_idx];
  assign handshake = tvalid_q && m_tready;

  // Next-state logic for the drain FSM, the occupancy count and the pointers.
  always_comb begin
    state_d     = state_q;
    burst_rem_d = burst_rem_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (op_en && (count_q != '0)) begin
          burst_rem_d = count_q;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pop      = 1'b1;
        tdata_d  = pop_data;
        tvalid_d = 1'b1;
        tlast_d  = (burst_rem_q == ONE);
        state_d  = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (handshake) begin
          if (burst_rem_q > ONE) begin
            // Reload the output register on the handshake edge so the
            // stream has no gap between beats.
            pop         = 1'b1;
            burst_rem_d = burst_rem_q - ONE;
            tdata_d     = pop_data;
            tlast_d     = (burst_rem_q == TWO);
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A write into a full buffer is allowed when a word leaves on the same
    // edge. Stack mode blocks writes while draining so the popped order stays intact.
    push   = wr_en && ((count_q < DEPTH_C) || pop) && !(IS_LIFO && (state_q == ST_DRAIN));
    drop_d = drop_q | (wr_en & ~push);

    case ({push, pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase

    if (!IS_LIFO) begin
      if (push) wr_ptr_d = wr_ptr_q + A_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + A_ONE;
    end

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      burst_rem_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      drop_q      <= 1'b0;
      done_q      <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      burst_rem_q <= burst_rem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      drop_q      <= drop_d;
      done_q      <= done_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  // Storage array. It has no reset because its contents are don't-care
  // until a word is written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= din;
  end

  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign wr_drop  = drop_q;
  assign done     = done_q;

endmodule
